// File: rtl/clut_thresh_gate_pkg.sv
// Shared clutter-map types, widths and helpers for the threshold/gate stages.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clut_thresh_gate_pkg;

    localparam int THR_W       = 16;
    localparam int RBIN_W_DFLT = 10;

    localparam logic [THR_W-1:0] THR_SAT = 16'hFFFF;

    // Bit positions inside align_err
    localparam int ERR_UNDF = 0;
    localparam int ERR_OVF  = 1;

    // Saturating increment used by the pass counters
    function automatic logic [THR_W-1:0] sat_inc(input logic [THR_W-1:0] v, input logic en);
        logic [THR_W-1:0] r;
        r = v;
        if (en && (v != THR_SAT)) begin
            r = v + THR_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/clut_sync_fifo.sv
// Single-clock FIFO with full/empty/count flags and registered (synchronous) read data.
// Latency: rd_dat valid the cycle after an accepted read; no write-to-read bypass.
// Backpressure: writes are dropped when full unless a read is accepted in the same cycle.
module clut_sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 64
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    assign full   = (count == CNT_FULL);
    assign empty  = (count == '0);
    assign rd_acc = rd_vld & ~empty;
    // A full FIFO still takes a write when a read frees a slot in the same cycle
    assign wr_acc = wr_vld & (~full | rd_acc);

    // Storage array; no reset needed, occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers, occupancy and registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rd_dat <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
                rd_dat <= mem[rd_ptr];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/clut_thresh_gate.sv
// Pairs buffered detections with clutter thresholds, scales/compares, counts passes per CPI.
// Latency: 3 cycles from thresh_valid to gate_valid, one sample per cycle.
// Backpressure: none; overflowing detections and unmatched thresholds are dropped and flagged.
module clut_thresh_gate
    import clut_thresh_gate_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int K_SHIFT    = 4,
    parameter int RBIN_W     = RBIN_W_DFLT
)(
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              clut_en,
    input  logic [7:0]        k_mul,
    input  logic [15:0]       k_off,
    input  logic              frame_end,
    input  logic              det_valid,
    input  logic [THR_W-1:0]  det_amp,
    input  logic [RBIN_W-1:0] det_rbin,
    input  logic              thresh_valid,
    input  logic [THR_W-1:0]  thresh_dat,
    output logic              gate_valid,
    output logic [THR_W-1:0]  gate_amp,
    output logic [RBIN_W-1:0] gate_rbin,
    output logic [THR_W-1:0]  gate_thr,
    output logic              gate_pass,
    output logic [15:0]       cpi_pass_cnt,
    output logic              cpi_done,
    output logic [1:0]        align_err
);

    typedef struct packed {
        logic [RBIN_W-1:0] rbin;
        logic [THR_W-1:0]  amp;
    } det_ent_t;

    localparam int ENT_W = $bits(det_ent_t);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    det_ent_t         wr_ent;
    det_ent_t         rd_ent;
    det_ent_t         s2_ent;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_cnt;
    logic             pop_vld;
    logic             undf_evt;
    logic             ovf_evt;

    logic             s1_vld;
    logic [THR_W-1:0] s1_thr;
    logic             s2_vld;
    logic [23:0]      s2_prod_s;
    logic [23:0]      prod;
    logic [24:0]      sum;
    logic [THR_W-1:0] thr_sat;
    logic             pass_evt;
    logic [15:0]      run_cnt;
    logic [15:0]      run_nxt;

    assign wr_ent.rbin = det_rbin;
    assign wr_ent.amp  = det_amp;

    // Only thresholds that find a buffered detection advance the pipeline
    assign pop_vld  = thresh_valid & (fifo_cnt != '0);
    assign undf_evt = thresh_valid & fifo_empty;
    assign ovf_evt  = det_valid & fifo_full & ~thresh_valid;

    clut_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_det_fifo (
        .clk    (sys_clk),
        .rst_n  (rst_n),
        .wr_vld (det_valid),
        .wr_dat (wr_ent),
        .rd_vld (thresh_valid),
        .rd_dat (rd_ent),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_cnt)
    );

    // Threshold scaling and saturating offset
    assign prod    = {8'd0, s1_thr} * {16'd0, k_mul};
    assign sum     = {1'b0, s2_prod_s} + {9'd0, k_off};
    assign thr_sat = (sum[24:16] != '0) ? THR_SAT : sum[15:0];

    // Stage 1: capture raw threshold alongside the FIFO read
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_thr <= '0;
        end else begin
            s1_vld <= pop_vld;
            s1_thr <= thresh_dat;
        end
    end

    // Stage 2: gain multiply and shift; carry the detection along
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld    <= 1'b0;
            s2_prod_s <= '0;
            s2_ent    <= '0;
        end else begin
            s2_vld    <= s1_vld;
            s2_prod_s <= prod >> K_SHIFT;
            s2_ent    <= rd_ent;
        end
    end

    // Stage 3: offset, saturate, strict compare; outputs held at zero when idle
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_valid <= 1'b0;
            gate_amp   <= '0;
            gate_rbin  <= '0;
            gate_thr   <= '0;
            gate_pass  <= 1'b0;
        end else if (s2_vld) begin
            gate_valid <= 1'b1;
            gate_amp   <= s2_ent.amp;
            gate_rbin  <= s2_ent.rbin;
            gate_thr   <= thr_sat;
            gate_pass  <= (s2_ent.amp > thr_sat) | ~clut_en;
        end else begin
            gate_valid <= 1'b0;
            gate_amp   <= '0;
            gate_rbin  <= '0;
            gate_thr   <= '0;
            gate_pass  <= 1'b0;
        end
    end

    // A pass on the frame_end cycle still belongs to the closing CPI
    assign pass_evt = gate_valid & gate_pass;
    assign run_nxt  = sat_inc(run_cnt, pass_evt);

    // Per-CPI pass counter and snapshot
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt      <= '0;
            cpi_pass_cnt <= '0;
            cpi_done     <= 1'b0;
        end else if (frame_end) begin
            run_cnt      <= '0;
            cpi_pass_cnt <= run_nxt;
            cpi_done     <= 1'b1;
        end else begin
            run_cnt      <= run_nxt;
            cpi_done     <= 1'b0;
        end
    end

    // Sticky alignment errors, cleared only by reset
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            align_err <= '0;
        end else begin
            if (undf_evt) begin
                align_err[ERR_UNDF] <= 1'b1;
            end
            if (ovf_evt) begin
                align_err[ERR_OVF] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clut_thresh_gate.sv
// Directed self-checking bench for clut_thresh_gate.
// Inputs driven and outputs sampled on the falling edge.
// Expected values are hand-computed constants.
module tb_clut_thresh_gate;

    logic        sys_clk;
    logic        rst_n;
    logic        clut_en;
    logic [7:0]  k_mul;
    logic [15:0] k_off;
    logic        frame_end;
    logic        det_valid;
    logic [15:0] det_amp;
    logic [9:0]  det_rbin;
    logic        thresh_valid;
    logic [15:0] thresh_dat;
    logic        gate_valid;
    logic [15:0] gate_amp;
    logic [9:0]  gate_rbin;
    logic [15:0] gate_thr;
    logic        gate_pass;
    logic [15:0] cpi_pass_cnt;
    logic        cpi_done;
    logic [1:0]  align_err;

    logic [62:0] all_out;
    int          n_chk;
    int          n_err;

    assign all_out = {gate_valid, gate_amp, gate_rbin, gate_thr, gate_pass,
                      cpi_pass_cnt, cpi_done, align_err};

    clut_thresh_gate #(
        .FIFO_DEPTH (64),
        .K_SHIFT    (4),
        .RBIN_W     (10)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .clut_en      (clut_en),
        .k_mul        (k_mul),
        .k_off        (k_off),
        .frame_end    (frame_end),
        .det_valid    (det_valid),
        .det_amp      (det_amp),
        .det_rbin     (det_rbin),
        .thresh_valid (thresh_valid),
        .thresh_dat   (thresh_dat),
        .gate_valid   (gate_valid),
        .gate_amp     (gate_amp),
        .gate_rbin    (gate_rbin),
        .gate_thr     (gate_thr),
        .gate_pass    (gate_pass),
        .cpi_pass_cnt (cpi_pass_cnt),
        .cpi_done     (cpi_done),
        .align_err    (align_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog sim_time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic chk_gate(input string tag, input logic v, input logic [15:0] amp,
                            input logic [9:0] rbin, input logic [15:0] thr, input logic p);
        chk(tag, {gate_valid, gate_pass, gate_thr, gate_rbin, gate_amp},
                 {v, p, thr, rbin, amp});
    endtask

    task automatic push_det(input logic [15:0] amp, input logic [9:0] rbin);
        det_valid = 1'b1;
        det_amp   = amp;
        det_rbin  = rbin;
        tick();
        det_valid = 1'b0;
    endtask

    // Issue one threshold and stop on the cycle its result is visible
    task automatic run_one(input logic [15:0] dat);
        thresh_valid = 1'b1;
        thresh_dat   = dat;
        tick();
        thresh_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        clut_en = 1'b0;
        k_mul = '0;
        k_off = '0;
        frame_end = 1'b0;
        det_valid = 1'b0;
        det_amp = '0;
        det_rbin = '0;
        thresh_valid = 1'b0;
        thresh_dat = '0;
        tick();
        tick();
        chk("reset_outputs", all_out, 0);

        // Basic pairing, strict compare, latency
        rst_n = 1'b1;
        clut_en = 1'b1;
        k_mul = 8'd16;
        k_off = 16'd0;
        tick();
        push_det(16'd101, 10'd5);
        push_det(16'd100, 10'd6);
        thresh_valid = 1'b1;
        thresh_dat = 16'd100;
        tick();
        chk("lat_cycle1", gate_valid, 0);
        tick();
        thresh_valid = 1'b0;
        chk("lat_cycle2", gate_valid, 0);
        tick();
        chk_gate("pair0_pass", 1'b1, 16'd101, 10'd5, 16'd100, 1'b1);
        tick();
        chk_gate("pair1_equal", 1'b1, 16'd100, 10'd6, 16'd100, 1'b0);
        tick();
        chk("idle_zero", {gate_valid, gate_amp, gate_rbin, gate_thr, gate_pass}, 0);

        // Saturation: 0xFFFF*255>>4 + 16 exceeds 16 bits
        push_det(16'hFFFF, 10'd7);
        k_mul = 8'd255;
        k_off = 16'd16;
        run_one(16'hFFFF);
        chk_gate("sat_thr", 1'b1, 16'hFFFF, 10'd7, 16'hFFFF, 1'b0);

        // Bypass passes regardless of amplitude
        clut_en = 1'b0;
        k_mul = 8'd16;
        k_off = 16'd0;
        push_det(16'd3, 10'd9);
        run_one(16'd500);
        chk_gate("bypass", 1'b1, 16'd3, 10'd9, 16'd500, 1'b1);
        clut_en = 1'b1;
        tick();

        // Overflow: 65 pushes into 64 entries
        for (int i = 0; i < 65; i++) begin
            push_det(16'(i), 10'(i));
            if (i == 63) chk("full_no_err", align_err, 2'b00);
        end
        chk("ovf_flag", align_err, 2'b10);
        for (int k = 0; k < 67; k++) begin
            if (k < 64) begin
                thresh_valid = 1'b1;
                thresh_dat = 16'd0;
            end else begin
                thresh_valid = 1'b0;
            end
            if (k >= 3) chk("drain_order", {gate_valid, gate_rbin, gate_amp},
                            {1'b1, 10'(k-3), 16'(k-3)});
            tick();
        end
        chk("drain_done", gate_valid, 0);
        thresh_valid = 1'b1;
        thresh_dat = 16'd0;
        tick();
        thresh_valid = 1'b0;
        chk("undf_flag", align_err, 2'b11);
        tick();
        tick();
        chk("undf_no_gate", gate_valid, 0);

        // Close the CPI: 1 + 1 + 63 passes so far
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        chk("cpi_cnt_prior", cpi_pass_cnt, 16'd65);
        chk("cpi_done_prior", cpi_done, 1);
        tick();
        chk("cpi_done_pulse", cpi_done, 0);

        // CPI of 10 samples, last 7 pass, frame_end with the 7th pass
        for (int i = 0; i < 10; i++) begin
            push_det((i < 3) ? 16'd50 : 16'd200, 10'(100 + i));
        end
        for (int k = 0; k < 13; k++) begin
            thresh_valid = (k < 10);
            thresh_dat = 16'd100;
            frame_end = (k == 12);
            if (k == 12) chk_gate("cpi_last_pass", 1'b1, 16'd200, 10'd109, 16'd100, 1'b1);
            tick();
        end
        frame_end = 1'b0;
        thresh_valid = 1'b0;
        chk("cpi_cnt7", cpi_pass_cnt, 16'd7);
        chk("cpi_done7", cpi_done, 1);
        tick();
        chk("cpi_hold7", {cpi_done, cpi_pass_cnt}, {1'b0, 16'd7});

        // Next CPI starts from zero
        push_det(16'd300, 10'd1);
        run_one(16'd100);
        chk_gate("next_pass", 1'b1, 16'd300, 10'd1, 16'd100, 1'b1);
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        chk("next_cpi_cnt", cpi_pass_cnt, 16'd1);

        // Reset mid-stream with buffered samples and data in flight
        for (int i = 0; i < 20; i++) begin
            push_det(16'(1000 + i), 10'(i));
        end
        thresh_valid = 1'b1;
        thresh_dat = 16'd10;
        tick();
        tick();
        tick();
        thresh_valid = 1'b0;
        chk("pre_rst_gate", gate_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", all_out, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_idle", {gate_valid, align_err}, 0);
        thresh_valid = 1'b1;
        tick();
        thresh_valid = 1'b0;
        chk("post_rst_undf", align_err, 2'b01);
        tick();
        tick();
        chk("post_rst_no_gate", gate_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/clut_thresh_gate.md
Name: clut_thresh_gate

Overview:
- Sits directly downstream of the clutter-map threshold generator (3x3 max-filtered thresh_valid/thresh_dat stream).
- Buffers the detection amplitude stream, which arrives earlier, and pairs each sample in order with its threshold.
- Scales the threshold and compares the amplitude against it; emits a per-sample pass flag.
- Keeps a per-CPI pass count and sticky alignment-error flags for software.

Parameters:
- FIFO_DEPTH, 64, entries in the detection alignment FIFO; power of two.
- K_SHIFT, 4, right shift applied after the threshold multiply; k_mul=16 gives unity gain.
- RBIN_W, 10, range-bin index width.

Ports:
- sys_clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clut_en  in  1  0 = bypass; every sample passes.
- k_mul  in  8  threshold gain, unsigned.
- k_off  in  16  threshold offset, unsigned.
- frame_end  in  1  one-cycle pulse marking the end of a CPI.
- det_valid  in  1  detection sample strobe.
- det_amp  in  16  detection amplitude, unsigned.
- det_rbin  in  RBIN_W  range bin of the detection sample.
- thresh_valid  in  1  threshold strobe from the upstream stage.
- thresh_dat  in  16  raw threshold, unsigned.
- gate_valid  out  1  result strobe.
- gate_amp  out  16  amplitude paired with the result.
- gate_rbin  out  RBIN_W  range bin paired with the result.
- gate_thr  out  16  scaled threshold used for the compare.
- gate_pass  out  1  amplitude exceeded the threshold, or bypass is active.
- cpi_pass_cnt  out  16  pass count of the last completed CPI.
- cpi_done  out  1  one-cycle pulse when cpi_pass_cnt updates.
- align_err  out  2  sticky flags: bit0 underflow, bit1 overflow.

Behaviour:
- Reset: all outputs 0; FIFO emptied; running counter 0. Reset asserted mid-CPI discards all buffered samples and any in-flight pipeline data.
- FIFO entry is {det_rbin, det_amp}, 16+RBIN_W bits, with synchronous read.
  - Push on det_valid.
  - Pop on thresh_valid.
- Pipeline from thresh_valid at cycle T:
  - T+1: FIFO data read and thresh_dat registered.
  - T+2: prod = thresh_dat*k_mul (24 bits); prod_s = prod >> K_SHIFT.
  - T+3: sum = prod_s + k_off (25 bits). Saturate to 16'hFFFF if sum > 16'hFFFF. Set pass = (det_amp > thr) or !clut_en. Register all outputs.
  - Latency is 3 cycles. Throughput is one sample per cycle with no bubbles.
- Outputs when gate_valid=0: gate_amp, gate_rbin, gate_thr and gate_pass are all 0.
- k_mul, k_off and clut_en are sampled in the stage that uses them. Software changes them only between CPIs.
- Strict compare: amp == thr gives pass=0.
- Full FIFO with det_valid and no pop:
  - Sample is dropped; align_err[1] is set.
  - Full with simultaneous push and pop: both accepted; occupancy unchanged; no error.
- Empty FIFO with thresh_valid:
  - A push in the same cycle is not forwarded to the pop, so no bypass.
  - Threshold is discarded; align_err[0] is set; no gate_valid is produced for it.
- Pass counter:
  - Increments on gate_valid & gate_pass and saturates at 16'hFFFF.
  - On frame_end, cpi_pass_cnt is loaded with the running count. If the current cycle also carries a pass, that pass is included. cpi_done pulses on the next cycle; the running count clears to 0.
  - Passes emerging in cycles after frame_end count toward the next CPI.
- align_err is sticky and is cleared only by reset.
- frame_end does not flush the FIFO. Residual occupancy at frame_end is legal and carries over.

Decomposition:
- Shared clutter-map package holds:
  - THR_W = 16.
  - RBIN_W default.
  - THR_SAT = 16'hFFFF.
  - The align_err bit indices: ERR_UNDF = 0, ERR_OVF = 1.
- One sub-module: clut_sync_fifo, a parameterised single-clock FIFO (width, depth) with full/empty/count and synchronous read. It must be reusable by the other clutter-map stages.
- Scale, compare and counter logic stay in the top.

Test Plan:
- clut_en=1, k_mul=16, k_off=0; det (amp=101, rbin=5), (amp=100, rbin=6), then 2 thresholds of 100 -> gate_thr=100 both; pass 1 then 0; rbin 5, 6 in order; each gate_valid 3 cycles after its thresh_valid.
- thresh_dat=16'hFFFF, k_mul=255, k_off=16 -> gate_thr=16'hFFFF; amp=16'hFFFF gives pass=0.
- clut_en=0, thresh 500, amp 3 -> pass=1, gate_thr=500.
- 65 det_valid with no thresholds -> align_err=2'b10; 64 thresholds return the first 64 samples; a 65th threshold sets align_err=2'b11 with no gate_valid.
- CPI of 10 samples, 7 passing; frame_end coincides with the 7th pass -> cpi_pass_cnt=7, cpi_done next cycle; next CPI's count starts at 0.
- rst_n pulsed low with 20 samples buffered -> all outputs 0 immediately; after release, a thresh_valid sets align_err[0].
